// File: rtl/memory_access.sv
// memory_access: MEM stage of the 5-stage core.
// Issues at most one data-memory request at a time, lines store data up with
// the byte lanes, extracts and extends load data, and registers the result
// into MEM/WB. Misaligned accesses never reach the bus; they retire at once
// without a register write and raise a one-cycle misalign_o pulse.
//
// Memory handshake: dmem_req_o is high for every cycle an aligned memop sits
// in MEM and has not yet been acknowledged. Address, write enable, byte
// enables and write data are stable while dmem_req_o is high, because
// stall_mem_o freezes the EX/MEM register feeding this stage. The transfer
// completes in the cycle where dmem_req_o and dmem_ack_i are both high; load
// data on dmem_rdata_i is sampled in that same cycle. An ack seen without a
// request is ignored.
module memory_access #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           alu_result_mem_i,
    input  logic [31:0]           latest_rs2_value_mem_i,
    input  logic                  load_store_forward_sel_mem_i,
    input  logic                  reg_write_en_mem_i,
    input  logic                  is_load_instr_mem_i,
    input  logic                  is_store_instr_mem_i,
    input  logic [4:0]            rd_label_mem_i,
    input  logic [1:0]            wb_sel_mem_i,
    input  logic [31:0]           pc_mem_i,
    input  logic [2:0]            funct3_mem_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [31:0]           dmem_rdata_i,
    output logic                  stall_mem_o,
    output logic [31:0]           rd_value_mem_o,
    output logic [31:0]           rd_value_wb_o,
    output logic [4:0]            rd_label_wb_o,
    output logic                  reg_write_en_wb_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  state_dbg_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The wait counter only needs to reach TIMEOUT; TIMEOUT = 0 disables it.
    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt_q;

    logic        mem_op;
    logic [1:0]  byte_off;
    logic        misaligned;
    logic        aligned_op;
    logic        timeout_hit;
    logic        abort;
    logic        stall;
    logic [31:0] store_data;
    logic [3:0]  lane_be;
    logic [31:0] load_shifted;
    logic [31:0] load_ext;
    logic [31:0] rd_value_mem;
    logic [31:0] wb_value;

    assign mem_op   = is_load_instr_mem_i | is_store_instr_mem_i;
    assign byte_off = alu_result_mem_i[1:0];

    // Half accesses need an even address, word accesses a multiple of four;
    // byte accesses (and the reserved size 11) are never misaligned.
    always_comb begin
        misaligned = 1'b0;
        case (funct3_mem_i[1:0])
            2'b01:   misaligned = mem_op & byte_off[0];
            2'b10:   misaligned = mem_op & (byte_off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign aligned_op = mem_op & ~misaligned;

    // Abort only once the counter has reached TIMEOUT and no ack arrived this
    // cycle; an ack in the last allowed cycle still completes the access.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_WAIT) && (wait_cnt_q == TIMEOUT_C);
    assign abort       = aligned_op & timeout_hit & ~dmem_ack_i;
    assign stall       = aligned_op & ~dmem_ack_i & ~abort;

    // Store data may come from the value that is being written back right now.
    assign store_data = load_store_forward_sel_mem_i ? rd_value_wb_o : latest_rs2_value_mem_i;

    // Byte enables follow the access size, shifted up to the addressed lane.
    always_comb begin
        lane_be = 4'b1111;
        case (funct3_mem_i[1:0])
            2'b00:   lane_be = 4'b0001 << byte_off;
            2'b01:   lane_be = 4'b0011 << byte_off;
            default: lane_be = 4'b1111;
        endcase
    end

    assign load_shifted = dmem_rdata_i >> {byte_off, 3'b000};

    // Extend the lane-aligned read data according to size and signedness.
    always_comb begin
        load_ext = load_shifted;
        case (funct3_mem_i)
            3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_ext = load_shifted;
            3'b100:  load_ext = {24'h000000, load_shifted[7:0]};
            3'b101:  load_ext = {16'h0000, load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    assign rd_value_mem = (wb_sel_mem_i == 2'b10) ? (pc_mem_i + 32'd4) : alu_result_mem_i;
    assign wb_value     = (wb_sel_mem_i == 2'b01) ? load_ext : rd_value_mem;

    assign dmem_req_o     = aligned_op;
    assign dmem_we_o      = aligned_op & is_store_instr_mem_i;
    assign dmem_addr_o    = {alu_result_mem_i[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be_o      = lane_be;
    assign dmem_wdata_o   = store_data << {byte_off, 3'b000};
    assign stall_mem_o    = stall;
    assign rd_value_mem_o = rd_value_mem;
    assign state_dbg_o    = state_q;

    // Request FSM, wait counter and MEM/WB register with error pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q           <= ST_IDLE;
            wait_cnt_q        <= '0;
            rd_value_wb_o     <= 32'd0;
            rd_label_wb_o     <= 5'd0;
            reg_write_en_wb_o <= 1'b0;
            misalign_o        <= 1'b0;
            bus_err_o         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wait_cnt_q <= '0;
                    if (aligned_op && !dmem_ack_i) begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (!aligned_op || dmem_ack_i || abort) begin
                        state_q    <= ST_IDLE;
                        wait_cnt_q <= '0;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt_q <= wait_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wait_cnt_q <= '0;
                end
            endcase

            if (stall) begin
                // Pipeline frozen: push a bubble, hold the rest of MEM/WB.
                reg_write_en_wb_o <= 1'b0;
                misalign_o        <= 1'b0;
                bus_err_o         <= 1'b0;
            end else begin
                rd_value_wb_o     <= wb_value;
                rd_label_wb_o     <= rd_label_mem_i;
                reg_write_en_wb_o <= reg_write_en_mem_i & ~is_store_instr_mem_i
                                     & ~misaligned & ~abort;
                misalign_o        <= misaligned;
                bus_err_o         <= abort;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed and randomized checks of the MEM stage against a
// transaction-level reference model (sizes, lanes and extension computed with
// plain arithmetic). TIMEOUT is set to 4 so the abort path is short.
module tb_memory_access;

    localparam int AW = 32;
    localparam int TO = 4;
    localparam int W  = 39; // {misalign, we, rd[4:0], value[31:0]}

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   alu_result_mem_i;
    logic [31:0]   latest_rs2_value_mem_i;
    logic          load_store_forward_sel_mem_i;
    logic          reg_write_en_mem_i;
    logic          is_load_instr_mem_i;
    logic          is_store_instr_mem_i;
    logic [4:0]    rd_label_mem_i;
    logic [1:0]    wb_sel_mem_i;
    logic [31:0]   pc_mem_i;
    logic [2:0]    funct3_mem_i;
    logic          dmem_req_o;
    logic          dmem_we_o;
    logic [AW-1:0] dmem_addr_o;
    logic [3:0]    dmem_be_o;
    logic [31:0]   dmem_wdata_o;
    logic          dmem_ack_i;
    logic [31:0]   dmem_rdata_i;
    logic          stall_mem_o;
    logic [31:0]   rd_value_mem_o;
    logic [31:0]   rd_value_wb_o;
    logic [4:0]    rd_label_wb_o;
    logic          reg_write_en_wb_o;
    logic          misalign_o;
    logic          bus_err_o;
    logic          state_dbg_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [31:0]  last_wb_value;
    logic         last_wb_known;

    // Clock and DUT
    always #5 clk_i = ~clk_i;

    memory_access #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i                        (clk_i),
        .rst_i                        (rst_i),
        .alu_result_mem_i             (alu_result_mem_i),
        .latest_rs2_value_mem_i       (latest_rs2_value_mem_i),
        .load_store_forward_sel_mem_i (load_store_forward_sel_mem_i),
        .reg_write_en_mem_i           (reg_write_en_mem_i),
        .is_load_instr_mem_i          (is_load_instr_mem_i),
        .is_store_instr_mem_i         (is_store_instr_mem_i),
        .rd_label_mem_i               (rd_label_mem_i),
        .wb_sel_mem_i                 (wb_sel_mem_i),
        .pc_mem_i                     (pc_mem_i),
        .funct3_mem_i                 (funct3_mem_i),
        .dmem_req_o                   (dmem_req_o),
        .dmem_we_o                    (dmem_we_o),
        .dmem_addr_o                  (dmem_addr_o),
        .dmem_be_o                    (dmem_be_o),
        .dmem_wdata_o                 (dmem_wdata_o),
        .dmem_ack_i                   (dmem_ack_i),
        .dmem_rdata_i                 (dmem_rdata_i),
        .stall_mem_o                  (stall_mem_o),
        .rd_value_mem_o               (rd_value_mem_o),
        .rd_value_wb_o                (rd_value_wb_o),
        .rd_label_wb_o                (rd_label_wb_o),
        .reg_write_en_wb_o            (reg_write_en_wb_o),
        .misalign_o                   (misalign_o),
        .bus_err_o                    (bus_err_o),
        .state_dbg_o                  (state_dbg_o)
    );

    // Reference model: access size in bytes from funct3.
    function automatic int model_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        if (f3[1:0] == 2'b01) return (addr % 2) != 0;
        if (f3[1:0] == 2'b10) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        int off;
        n   = model_size(f3);
        off = int'(addr % 4);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] sdata, input logic [31:0] addr);
        logic [31:0] mult;
        mult = 32'd1 << (8 * (addr % 4));
        return sdata * mult;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [2:0] f3);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        case (f3)
            3'b000: begin
                v = v % 256;
                if (v >= 32'd128) v = v - 32'd256;
            end
            3'b001: begin
                v = v % 65536;
                if (v >= 32'd32768) v = v - 32'd65536;
            end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = v;
        endcase
        return v;
    endfunction

    // Driver tasks
    task automatic clear_inputs();
        alu_result_mem_i             = 32'd0;
        latest_rs2_value_mem_i       = 32'd0;
        load_store_forward_sel_mem_i = 1'b0;
        reg_write_en_mem_i           = 1'b0;
        is_load_instr_mem_i          = 1'b0;
        is_store_instr_mem_i         = 1'b0;
        rd_label_mem_i               = 5'd0;
        wb_sel_mem_i                 = 2'b00;
        pc_mem_i                     = 32'd0;
        funct3_mem_i                 = 3'b000;
        dmem_ack_i                   = 1'b0;
        dmem_rdata_i                 = 32'd0;
    endtask

    task automatic drive_instr(input logic ld, input logic st, input logic we,
                               input logic [1:0] wb_sel, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic fwd, input logic [4:0] rd, input logic [31:0] pc);
        is_load_instr_mem_i          = ld;
        is_store_instr_mem_i         = st;
        reg_write_en_mem_i           = we;
        wb_sel_mem_i                 = wb_sel;
        funct3_mem_i                 = f3;
        alu_result_mem_i             = addr;
        latest_rs2_value_mem_i       = data;
        load_store_forward_sel_mem_i = fwd;
        rd_label_mem_i               = rd;
        pc_mem_i                     = pc;
    endtask

    // One instruction through MEM: drive it, ack after `delay` cycles if it
    // reaches the bus, check the bus side every cycle and the WB result.
    // Entered and left at posedge + 1.
    task automatic run_txn(input logic ld, input logic st, input logic we,
                           input logic [1:0] wb_sel, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic fwd, input logic [4:0] rd, input logic [31:0] pc,
                           input logic [31:0] rdata, input int delay);
        logic         mem_op;
        logic         mis;
        logic         aligned;
        logic         exp_stall;
        logic [31:0]  sdata;
        logic [31:0]  rdv;
        logic [31:0]  wbv;
        logic [W-1:0] item;
        int           eff_delay;
        mem_op    = ld | st;
        mis       = mem_op && model_misaligned(f3, addr);
        aligned   = mem_op && !mis;
        sdata     = fwd ? last_wb_value : data;
        rdv       = (wb_sel == 2'd2) ? pc + 32'd4 : addr;
        wbv       = (wb_sel == 2'd1) ? model_load(rdata, addr, f3) : rdv;
        exp_q.push_back({mis, we & ~st & ~mis, rd, wbv});
        eff_delay = aligned ? delay : 0;
        drive_instr(ld, st, we, wb_sel, f3, addr, data, fwd, rd, pc);
        for (int c = 0; c <= eff_delay; c++) begin
            dmem_ack_i   = aligned && (c == eff_delay);
            dmem_rdata_i = dmem_ack_i ? rdata : $urandom;
            exp_stall    = aligned && (c < eff_delay);
            @(negedge clk_i);
            n_checks++;
            if (dmem_req_o !== aligned) begin
                n_fail++;
                $display("FAIL req: got %b expected %b (addr %h cycle %0d)", dmem_req_o, aligned, addr, c);
            end
            n_checks++;
            if (stall_mem_o !== exp_stall) begin
                n_fail++;
                $display("FAIL stall: got %b expected %b (addr %h cycle %0d)", stall_mem_o, exp_stall, addr, c);
            end
            n_checks++;
            if (rd_value_mem_o !== rdv) begin
                n_fail++;
                $display("FAIL rd_value_mem: got %h expected %h", rd_value_mem_o, rdv);
            end
            n_checks++;
            if (state_dbg_o !== (c > 0)) begin
                n_fail++;
                $display("FAIL state: got %b expected %b (cycle %0d)", state_dbg_o, (c > 0), c);
            end
            if (aligned) begin
                n_checks++;
                if (dmem_addr_o !== (addr & 32'hFFFF_FFFC)) begin
                    n_fail++;
                    $display("FAIL addr: got %h expected %h", dmem_addr_o, addr & 32'hFFFF_FFFC);
                end
                n_checks++;
                if (dmem_we_o !== st) begin
                    n_fail++;
                    $display("FAIL we: got %b expected %b", dmem_we_o, st);
                end
                n_checks++;
                if (dmem_be_o !== model_be(f3, addr)) begin
                    n_fail++;
                    $display("FAIL be: got %b expected %b (addr %h f3 %b)", dmem_be_o, model_be(f3, addr), addr, f3);
                end
                if (st) begin
                    n_checks++;
                    if (dmem_wdata_o !== model_wdata(sdata, addr)) begin
                        n_fail++;
                        $display("FAIL wdata: got %h expected %h", dmem_wdata_o, model_wdata(sdata, addr));
                    end
                end
            end
            @(posedge clk_i);
            #1;
            if (c < eff_delay) begin
                n_checks++;
                if (reg_write_en_wb_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bubble: got we %b expected 0 (cycle %0d)", reg_write_en_wb_o, c);
                end
            end
        end
        dmem_ack_i = 1'b0;
        item = exp_q.pop_front();
        n_checks++;
        if (misalign_o !== item[38]) begin
            n_fail++;
            $display("FAIL misalign: got %b expected %b", misalign_o, item[38]);
        end
        n_checks++;
        if (reg_write_en_wb_o !== item[37]) begin
            n_fail++;
            $display("FAIL wb_we: got %b expected %b", reg_write_en_wb_o, item[37]);
        end
        n_checks++;
        if (bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_err: got %b expected 0", bus_err_o);
        end
        if (!item[38]) begin
            n_checks++;
            if (rd_label_wb_o !== item[36:32]) begin
                n_fail++;
                $display("FAIL wb_label: got %0d expected %0d", rd_label_wb_o, item[36:32]);
            end
            n_checks++;
            if (rd_value_wb_o !== item[31:0]) begin
                n_fail++;
                $display("FAIL wb_value: got %h expected %h", rd_value_wb_o, item[31:0]);
            end
            last_wb_value = item[31:0];
            last_wb_known = 1'b1;
        end else begin
            last_wb_known = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({rd_value_wb_o, rd_label_wb_o, reg_write_en_wb_o, misalign_o, bus_err_o, state_dbg_o} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_state: got value %h label %0d we %b mis %b err %b state %b expected all 0",
                     rd_value_wb_o, rd_label_wb_o, reg_write_en_wb_o, misalign_o, bus_err_o, state_dbg_o);
        end
        n_checks++;
        if (dmem_req_o !== 1'b0 || stall_mem_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: got req %b stall %b expected 0 0", dmem_req_o, stall_mem_o);
        end
        rst_i         = 1'b1;
        last_wb_value = 32'd0;
        last_wb_known = 1'b1;
    endtask

    task automatic test_alu_op();
        run_txn(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_1234, 32'd0, 1'b0, 5'd5, 32'h100, 32'd0, 0);
        run_txn(1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_0055, 32'd0, 1'b0, 5'd1, 32'h200, 32'd0, 0);
        run_txn(1'b0, 1'b0, 1'b1, 2'b11, 3'b000, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd31, 32'hFFFF_FFFC, 32'd0, 0);
    endtask

    task automatic test_lb_same_cycle();
        run_txn(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_1003, 32'd0, 1'b0, 5'd6, 32'h300, 32'h80FF_FF7F, 0);
        run_txn(1'b1, 1'b0, 1'b1, 2'b01, 3'b100, 32'h0000_1003, 32'd0, 1'b0, 5'd6, 32'h304, 32'h80FF_FF7F, 0);
    endtask

    task automatic test_sh_delayed();
        run_txn(1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 5'd0, 32'h400, 32'd0, 3);
    endtask

    task automatic test_lw_misalign();
        run_txn(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h0000_0001, 32'd0, 1'b0, 5'd8, 32'h500, 32'h1111_2222, 0);
        run_txn(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_0077, 32'd0, 1'b0, 5'd9, 32'h504, 32'd0, 0);
    endtask

    task automatic test_timeout();
        drive_instr(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h0000_3000, 32'd0, 1'b0, 5'd7, 32'h600);
        dmem_ack_i = 1'b0;
        for (int c = 0; c <= TO; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (stall_mem_o !== (c < TO)) begin
                n_fail++;
                $display("FAIL timeout_stall: got %b expected %b (cycle %0d)", stall_mem_o, (c < TO), c);
            end
            @(posedge clk_i);
            #1;
            if (c < TO) begin
                n_checks++;
                if (reg_write_en_wb_o !== 1'b0 || bus_err_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_wait: got we %b err %b expected 0 0 (cycle %0d)",
                             reg_write_en_wb_o, bus_err_o, c);
                end
            end
        end
        n_checks++;
        if (bus_err_o !== 1'b1 || reg_write_en_wb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got err %b we %b expected 1 0", bus_err_o, reg_write_en_wb_o);
        end
        clear_inputs();
        @(negedge clk_i);
        n_checks++;
        if (dmem_req_o !== 1'b0 || state_dbg_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: got req %b state %b expected 0 0", dmem_req_o, state_dbg_o);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if (bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got err %b expected 0", bus_err_o);
        end
        last_wb_known = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        run_txn(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'hCAFE_0000, 32'd0, 1'b0, 5'd9, 32'h700, 32'd0, 0);
        drive_instr(1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_4000, 32'h1234_5678, 1'b0, 5'd0, 32'h704);
        dmem_ack_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (stall_mem_o !== 1'b1 || state_dbg_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_wait: got stall %b state %b expected 1 1", stall_mem_o, state_dbg_o);
        end
        rst_i = 1'b0;
        clear_inputs();
        @(posedge clk_i);
        #1;
        n_checks++;
        if ({rd_value_wb_o, rd_label_wb_o, reg_write_en_wb_o, misalign_o, bus_err_o, state_dbg_o} !== 41'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got value %h label %0d we %b mis %b err %b state %b expected all 0",
                     rd_value_wb_o, rd_label_wb_o, reg_write_en_wb_o, misalign_o, bus_err_o, state_dbg_o);
        end
        n_checks++;
        if (dmem_req_o !== 1'b0 || stall_mem_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_bus: got req %b stall %b expected 0 0", dmem_req_o, stall_mem_o);
        end
        rst_i      = 1'b1;
        dmem_ack_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (dmem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack_req: got %b expected 0", dmem_req_o);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if (reg_write_en_wb_o !== 1'b0 || state_dbg_o !== 1'b0 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack: got we %b state %b err %b expected 0 0 0",
                     reg_write_en_wb_o, state_dbg_o, bus_err_o);
        end
        dmem_ack_i    = 1'b0;
        last_wb_value = 32'd0;
        last_wb_known = 1'b1;
    endtask

    task automatic test_random_back_to_back();
        logic [2:0] f3_tab[5];
        int         kind;
        logic [2:0] f3;
        logic       fwd;
        f3_tab[0] = 3'b000;
        f3_tab[1] = 3'b001;
        f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100;
        f3_tab[4] = 3'b101;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            f3   = f3_tab[$urandom_range(0, 4)];
            case (kind)
                0: run_txn(1'b0, 1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
                           f3, $urandom, $urandom, 1'b0, 5'($urandom_range(0, 31)), $urandom, $urandom, 0);
                1: run_txn(1'b0, 1'b0, 1'b1, 2'b10, f3, $urandom, $urandom, 1'b0,
                           5'($urandom_range(0, 31)), $urandom, $urandom, 0);
                2: run_txn(1'b1, 1'b0, 1'b1, 2'b01, f3, $urandom, $urandom, 1'b0,
                           5'($urandom_range(0, 31)), $urandom, $urandom, $urandom_range(0, TO - 1));
                default: begin
                    fwd = last_wb_known && ($urandom_range(0, 1) != 0);
                    run_txn(1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'b00, f3, $urandom, $urandom, fwd,
                            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom_range(0, TO - 1));
                end
            endcase
        end
    endtask

    // Test sequence and final report
    initial begin
        clear_inputs();
        rst_i         = 1'b0;
        last_wb_value = 32'd0;
        last_wb_known = 1'b0;
        test_reset();
        test_alu_op();
        test_lb_same_cycle();
        test_sh_delayed();
        test_lw_misalign();
        test_timeout();
        test_reset_mid_wait();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
